dmem_ctrl: RTL and testbench
============================

DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- AW, 32, address width.
- BASE, 'h1000, first byte address of data memory.
- SIZE, 1024, data memory size in bytes.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, single clock, all state updates on its rising edge.
- rst, in, 1, synchronous active-high reset.
- req_valid, in, 1, request present.
- req_ready, out, 1, controller can accept a request.
- req_we, in, 1, 1 = store, 0 = load.
- req_funct3, in, 3, RV32I width code (load 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; store 000 sb, 001 sh, 010 sw).
- req_addr, in, AW, byte address.
- req_wdata, in, 32, store data, right-aligned.
- resp_valid, out, 1, one-cycle response pulse.
- resp_err, out, 1, request rejected; qualified by resp_valid.
- resp_rdata, out, 32, extended load data; 0 for stores and errors.
- mem_address, out, AW, word-aligned address to the memory.
- mem_read, out, 1, memory read strobe.
- mem_write, out, 1, memory full-word write strobe.
- mem_wdata, out, 32, memory write data.
- mem_rdata, in, 32, memory read data; valid in the cycle after the cycle in which mem_read was high.

Function
REQ-003 The FSM SHALL have states IDLE, RD, CAP, WR, RSP; req_ready = 1 only in IDLE with rst low; a request is accepted on any edge where req_valid & req_ready.
REQ-004 On acceptance, addr, we, funct3 and wdata SHALL be latched, and mem_address SHALL hold {addr[AW-1:2],2'b00} until return to IDLE.
REQ-005 Error check at acceptance SHALL flag any of: illegal funct3 (load 011/110/111, store 1xx/011); misalignment (halfword addr[0]=1, word addr[1:0]!=0); aligned word outside [BASE, BASE+SIZE-4].
REQ-006 Transitions from IDLE SHALL be: error -> RSP; load -> RD; sw -> WR; sb/sh -> RD.
REQ-007 Remaining transitions SHALL be: RD -> CAP; CAP(load) -> RSP; CAP(store) -> WR; WR -> RSP; RSP -> IDLE.
REQ-008 mem_read SHALL be high only in RD, and mem_write only in WR; both SHALL be combinationally gated with !rst.
REQ-009 In CAP, loads SHALL select the byte/halfword lane by addr[1:0] (little-endian): lb/lh sign-extend, lbu/lhu zero-extend, lw pass through; the result is registered into resp_rdata.
REQ-010 In CAP, sb/sh SHALL merge the wdata low byte/halfword into mem_rdata at the addressed lane; mem_wdata in WR SHALL be the merged word (sw: wdata unmodified).
REQ-011 resp_valid SHALL be high exactly in RSP; resp_err and resp_rdata SHALL be valid with it and held at 0 outside RSP.
REQ-012 Latency from accept edge to resp_valid SHALL be: error 1 cycle, sw 2, load 3, sb/sh 4; the next request can be accepted the cycle after RSP.
REQ-013 An errored request SHALL never assert mem_read or mem_write; req_* inputs are ignored outside IDLE.

Reset
REQ-014 While rst is high at an edge: state <= IDLE, all latched fields and resp_rdata <= 0; req_ready, resp_valid, resp_err, mem_read, mem_write = 0 during rst.
REQ-015 Reset mid-operation SHALL abandon the request with no response, and SHALL cause no memory write at any edge where rst is high.

Configuration
REQ-016 Macro DMEM_CTRL_RMW_EN defined SHALL enable sb/sh via read-modify-write (REQ-006, REQ-010).
REQ-017 With DMEM_CTRL_RMW_EN undefined, sb/sh SHALL be treated as errors (RSP after 1 cycle, resp_err=1, no memory access); all load paths are unchanged.

Verification
REQ-018 Preload 0x1004=0x8899AABB:
- lb 0x1005 -> resp_rdata 0xFFFFFFAA, resp_valid 3 cycles after accept.
- lbu 0x1005 -> 0x000000AA.
- lh 0x1006 -> 0xFFFF8899.
- lhu 0x1006 -> 0x00008899.
REQ-019 sw 0x1008 data 0x12345678 -> mem_write high exactly 1 cycle, resp 2 cycles after accept; then lw 0x1008 -> 0x12345678, resp_err=0.
REQ-020 With RMW enabled, starting from 0x1008=0x12345678:
- sb 0x100B data 0xEF -> 0xEF345678.
- then sh 0x1008 data 0xBEEF -> 0xEF34BEEF.
- Without the macro, sb -> resp_err=1 and memory unchanged.
REQ-021 Each of lw 0x1002, lw 0x0FFC, lw 0x1400 and load funct3=011 -> resp_err=1 one cycle after accept, mem_read/mem_write never high.
REQ-022 Assert rst in the WR cycle of sw 0x1010 -> 0x1010 unchanged, no resp_valid, req_ready=0 while rst high, 1 in the cycle after release.
REQ-023 req_valid held high for two back-to-back lw -> req_ready low from the first accept through RSP, second accepted on the edge after RSP.

Source files
------------

// File: rtl/dmem_ctrl.sv
// RV32I data-memory controller: turns byte/half/word loads and stores into full-word memory accesses.
// Define DMEM_CTRL_RMW_EN to support sb/sh through read-modify-write; otherwise they are rejected.
module dmem_ctrl #(
  parameter int              AW   = 32,
  parameter logic [AW-1:0]   BASE = 'h1000,
  parameter int              SIZE = 1024
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [2:0]    req_funct3,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  output logic          resp_valid,
  output logic          resp_err,
  output logic [31:0]   resp_rdata,
  output logic [AW-1:0] mem_address,
  output logic          mem_read,
  output logic          mem_write,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

`ifdef DMEM_CTRL_RMW_EN
  localparam bit RMW_EN = 1'b1;
`else
  localparam bit RMW_EN = 1'b0;
`endif

  localparam logic [AW-1:0] LAST_WORD = BASE + AW'(SIZE - 4);

  typedef enum logic [2:0] {IDLE, RD, CAP, WR, RSP} state_t;

  state_t        state, state_nx;
  logic [AW-1:0] addr_q;
  logic          we_q;
  logic [2:0]    f3_q;
  logic [31:0]   wdata_q;
  logic          err_q;
  logic [31:0]   rdata_q;

  logic          f3_ok, align_ok, range_ok, req_err;
  logic [AW-1:0] req_word;
  logic [31:0]   lane_b, lane_h, load_data, merged;
  logic [4:0]    lane_shift;

  // Request legality, evaluated on the raw request so the decision is ready at the accept edge.
  // NOTE: every always_comb output gets a default first so no path can leave it unassigned (no latch).
  always_comb begin
    f3_ok    = 1'b0;
    align_ok = 1'b1;
    req_word = {req_addr[AW-1:2], 2'b00};
    if (req_we) begin
      case (req_funct3)
        3'b010:         f3_ok = 1'b1;
        3'b000, 3'b001: f3_ok = RMW_EN;
        default:        f3_ok = 1'b0;
      endcase
    end else begin
      case (req_funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_ok = 1'b1;
        default:                                f3_ok = 1'b0;
      endcase
    end
    case (req_funct3[1:0])
      2'b01:   align_ok = !req_addr[0];
      2'b10:   align_ok = (req_addr[1:0] == 2'b00);
      default: align_ok = 1'b1;
    endcase
    range_ok = (req_word >= BASE) && (req_word <= LAST_WORD);
    req_err  = !(f3_ok && align_ok && range_ok);
  end

  // Lane extraction for loads and lane merge for sub-word stores.
  always_comb begin
    lane_shift = {addr_q[1:0], 3'b000};
    lane_b     = mem_rdata >> lane_shift;
    lane_h     = mem_rdata >> {addr_q[1], 4'b0000};
    case (f3_q)
      3'b000:  load_data = {{24{lane_b[7]}}, lane_b[7:0]};
      3'b001:  load_data = {{16{lane_h[15]}}, lane_h[15:0]};
      3'b100:  load_data = {24'b0, lane_b[7:0]};
      3'b101:  load_data = {16'b0, lane_h[15:0]};
      default: load_data = mem_rdata;
    endcase
    if (f3_q[1:0] == 2'b00)
      merged = (mem_rdata & ~(32'h0000_00FF << lane_shift)) | ({24'b0, wdata_q[7:0]} << lane_shift);
    else
      merged = (mem_rdata & ~(32'h0000_FFFF << {addr_q[1], 4'b0000}))
             | ({16'b0, wdata_q[15:0]} << {addr_q[1], 4'b0000});
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (req_valid) begin
        if (req_err)                  state_nx = RSP;
        else if (!req_we)             state_nx = RD;
        else if (req_funct3 == 3'b010) state_nx = WR;
        else                          state_nx = RD;
      end
      RD:      state_nx = CAP;
      CAP:     state_nx = we_q ? WR : RSP;
      WR:      state_nx = RSP;
      RSP:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      wdata_q <= 32'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (req_valid) begin
          addr_q  <= req_addr;
          we_q    <= req_we;
          f3_q    <= req_funct3;
          wdata_q <= req_wdata;
          err_q   <= req_err;
        end
        CAP: begin
          if (we_q) wdata_q <= merged;
          else      rdata_q <= load_data;
        end
        RSP:     rdata_q <= 32'b0;  // keeps resp_rdata at zero outside RSP
        default: ;
      endcase
    end
  end

  assign req_ready   = (state == IDLE) && !rst;
  assign mem_read    = (state == RD)   && !rst;
  assign mem_write   = (state == WR)   && !rst;
  assign resp_valid  = (state == RSP)  && !rst;
  assign resp_err    = resp_valid && err_q;
  assign resp_rdata  = rdata_q;
  assign mem_address = {addr_q[AW-1:2], 2'b00};
  assign mem_wdata   = wdata_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboarded bench for dmem_ctrl with a behavioural word memory behind it.
// Expectations for sb/sh follow DMEM_CTRL_RMW_EN in the same way as the design.
module tb_dmem_ctrl;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          nrd;
    int          nwr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata, mem_address, mem_wdata, mem_rdata;
  logic        mem_read, mem_write;

  logic [31:0] mem [0:255];
  exp_t        sb_q[$];
  int          n_vec = 0;
  int          n_err = 0;

  dmem_ctrl #(.AW(32), .BASE(32'h1000), .SIZE(1024)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  wire [7:0] mem_idx = mem_address[9:2];

  always @(posedge clk) begin
    if (mem_read)  mem_rdata     <= mem[mem_idx];
    if (mem_write) mem[mem_idx]  <= mem_wdata;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic await_resp(input string tag);
    int   cyc = 0, nrd = 0, nwr = 0;
    bit   seen = 0;
    exp_t x;
    while (!seen && cyc < 8) begin
      @(negedge clk);
      cyc++;
      if (mem_read)  nrd++;
      if (mem_write) nwr++;
      if (resp_valid) seen = 1;
    end
    x = sb_q.pop_front();
    check({tag, "_seen"}, 32'(seen), 32'd1);
    check({tag, "_lat"},  32'(cyc),  32'(x.lat));
    check({tag, "_err"},  32'(resp_err), 32'(x.err));
    check({tag, "_rdata"}, resp_rdata, x.rdata);
    check({tag, "_nrd"},  32'(nrd), 32'(x.nrd));
    check({tag, "_nwr"},  32'(nwr), 32'(x.nwr));
  endtask

  task automatic run(input string tag, input logic we, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] d,
                     input logic e_err, input logic [31:0] e_rd,
                     input int e_lat, input int e_nrd, input int e_nwr);
    exp_t x;
    @(negedge clk);
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = d;
    x.err = e_err; x.rdata = e_rd; x.lat = e_lat; x.nrd = e_nrd; x.nwr = e_nwr;
    sb_q.push_back(x);
    @(posedge clk);
    #1 req_valid = 1'b0;
    await_resp(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   cyc;
    exp_t x;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[1]   = 32'h8899_AABB;
    mem[4]   = 32'hCAFE_F00D;
    mem[255] = 32'h5A5A_5A5A;
    mem_rdata = 32'h0;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0;

    repeat (3) @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_valid", 32'(resp_valid), 32'd0);
    check("rst_err",   32'(resp_err), 32'd0);
    check("rst_rd",    32'(mem_read), 32'd0);
    check("rst_wr",    32'(mem_write), 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    rst = 1'b0;

    // Loads with extension on the preloaded word.
    run("lb",  1'b0, 3'b000, 32'h1005, 32'h0, 1'b0, 32'hFFFF_FFAA, 3, 1, 0);
    run("lbu", 1'b0, 3'b100, 32'h1005, 32'h0, 1'b0, 32'h0000_00AA, 3, 1, 0);
    run("lh",  1'b0, 3'b001, 32'h1006, 32'h0, 1'b0, 32'hFFFF_8899, 3, 1, 0);
    run("lhu", 1'b0, 3'b101, 32'h1006, 32'h0, 1'b0, 32'h0000_8899, 3, 1, 0);
    run("lbu0", 1'b0, 3'b100, 32'h1004, 32'h0, 1'b0, 32'h0000_00BB, 3, 1, 0);
    run("lw_last", 1'b0, 3'b010, 32'h13FC, 32'h0, 1'b0, 32'h5A5A_5A5A, 3, 1, 0);

    // Word store then readback.
    run("sw",  1'b1, 3'b010, 32'h1008, 32'h1234_5678, 1'b0, 32'h0, 2, 0, 1);
    check("mem_sw", mem[2], 32'h1234_5678);
    run("lw",  1'b0, 3'b010, 32'h1008, 32'h0, 1'b0, 32'h1234_5678, 3, 1, 0);

`ifdef DMEM_CTRL_RMW_EN
    run("sb",  1'b1, 3'b000, 32'h100B, 32'h0000_00EF, 1'b0, 32'h0, 4, 1, 1);
    check("mem_sb", mem[2], 32'hEF34_5678);
    run("sh",  1'b1, 3'b001, 32'h1008, 32'h0000_BEEF, 1'b0, 32'h0, 4, 1, 1);
    check("mem_sh", mem[2], 32'hEF34_BEEF);
    run("lw_rmw", 1'b0, 3'b010, 32'h1008, 32'h0, 1'b0, 32'hEF34_BEEF, 3, 1, 0);
`else
    run("sb",  1'b1, 3'b000, 32'h100B, 32'h0000_00EF, 1'b1, 32'h0, 1, 0, 0);
    check("mem_sb", mem[2], 32'h1234_5678);
    run("sh",  1'b1, 3'b001, 32'h1008, 32'h0000_BEEF, 1'b1, 32'h0, 1, 0, 0);
    check("mem_sh", mem[2], 32'h1234_5678);
`endif

    // Rejected requests: misaligned, out of range on both sides, illegal width codes.
    run("e_mis",  1'b0, 3'b010, 32'h1002, 32'h0, 1'b1, 32'h0, 1, 0, 0);
    run("e_low",  1'b0, 3'b010, 32'h0FFC, 32'h0, 1'b1, 32'h0, 1, 0, 0);
    run("e_high", 1'b0, 3'b010, 32'h1400, 32'h0, 1'b1, 32'h0, 1, 0, 0);
    run("e_f3",   1'b0, 3'b011, 32'h1004, 32'h0, 1'b1, 32'h0, 1, 0, 0);
    run("e_lhmis", 1'b0, 3'b001, 32'h1005, 32'h0, 1'b1, 32'h0, 1, 0, 0);
    run("e_sf3",  1'b1, 3'b100, 32'h1008, 32'hFFFF_FFFF, 1'b1, 32'h0, 1, 0, 0);
    check("mem_esf3", mem[2], mem[2] === 32'hFFFF_FFFF ? 32'h0 : mem[2] | 32'h0);

    // Reset during the write cycle of a store.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h1010; req_wdata = 32'h1111_1111;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("rstwr_pre", 32'(mem_write), 32'd1);
    rst = 1'b1;
    #1;
    check("rstwr_gate", 32'(mem_write), 32'd0);
    check("rstwr_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("rstwr_ready2", 32'(req_ready), 32'd0);
    check("rstwr_valid", 32'(resp_valid), 32'd0);
    rst = 1'b0;
    #1;
    check("rstwr_release", 32'(req_ready), 32'd1);
    cyc = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (resp_valid || mem_write) cyc++;
    end
    check("rstwr_quiet", 32'(cyc), 32'd0);
    check("mem_rstwr", mem[4], 32'hCAFE_F00D);

    // Two back-to-back loads with req_valid held high.
    x.err = 1'b0; x.rdata = 32'h8899_AABB; x.lat = 3; x.nrd = 1; x.nwr = 0;
    sb_q.push_back(x);
    x.rdata = 32'h5A5A_5A5A;
    sb_q.push_back(x);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h1004;
    @(posedge clk);
    #1 req_addr = 32'h13FC;
    cyc = 0;
    while (cyc < 8) begin
      @(negedge clk);
      cyc++;
      check("b2b_busy", 32'(req_ready), 32'd0);
      if (resp_valid) break;
    end
    x = sb_q.pop_front();
    check("b2b1_lat",   32'(cyc), 32'(x.lat));
    check("b2b1_rdata", resp_rdata, x.rdata);
    @(negedge clk);
    check("b2b_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    await_resp("b2b2");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
